// File: rtl/mdu_ctrl.sv
`timescale 1ns/1ps
// mdu_ctrl: M-extension sequencer driving an external two-cycle multiplier plus an optional restoring divider.
// Build option MDU_DIV_EN compiles the divider in; without it divide ops complete at once with out_illegal set.
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_word,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_illegal,
    output logic        mul_valid,
    output logic [63:0] mul_a,
    output logic [63:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c
);

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

`ifdef MDU_DIV_EN
    typedef enum logic [2:0] {IDLE, MUL_ISSUE, MUL_WAIT, DIV_RUN, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, MUL_ISSUE, MUL_WAIT, RESP} state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        is_div;
    logic        op_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic        word_q;
    logic        resp_load;
    logic        resp_illegal;
    logic [63:0] resp_value;
    logic        mul_start;
    logic        div_start;

    // W results are always sign-extended from bit 31, unsigned ops included
    function automatic logic [63:0] wext(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [63:0] opnd(input logic w, input logic sx, input logic [63:0] v);
        if (!w)
            return v;
        return sx ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
    endfunction

    assign accept    = in_valid & in_ready & ~flush;
    assign is_div    = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    assign op_signed = (in_op != OP_DIVU) && (in_op != OP_REMU);
    assign ext_a     = opnd(in_word, op_signed, in_a);
    assign ext_b     = opnd(in_word, op_signed, in_b);

    assign in_ready  = reset && (state == IDLE);
    assign out_valid = (state == RESP);
    assign mul_valid = (state == MUL_ISSUE);

`ifdef MDU_DIV_EN
    logic [63:0] div_rem;
    logic [63:0] div_quo;
    logic [63:0] div_dsr;
    logic [6:0]  div_cnt;
    logic        neg_q;
    logic        neg_r;
    logic        sel_rem;
    logic        op_rem;
    logic        sign_a;
    logic        sign_b;
    logic [63:0] abs_a;
    logic [63:0] abs_b;
    logic        div_zero;
    logic        div_ovf;
    logic [64:0] rem_sh;
    logic [64:0] rem_sub;
    logic [63:0] rem_nx;
    logic [63:0] quo_nx;
    logic [63:0] q_fix;
    logic [63:0] r_fix;

    assign op_rem   = (in_op == OP_REM) || (in_op == OP_REMU);
    assign sign_a   = op_signed & ext_a[63];
    assign sign_b   = op_signed & ext_b[63];
    assign abs_a    = sign_a ? -ext_a : ext_a;
    assign abs_b    = sign_b ? -ext_b : ext_b;
    assign div_zero = (ext_b == '0);
    assign div_ovf  = op_signed && (ext_b == '1) &&
                      (ext_a == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));

    // Borrow out of the 65-bit trial subtraction decides the quotient bit
    assign rem_sh  = {div_rem, div_quo[63]};
    assign rem_sub = rem_sh - {1'b0, div_dsr};
    assign rem_nx  = rem_sub[64] ? rem_sh[63:0] : rem_sub[63:0];
    assign quo_nx  = {div_quo[62:0], ~rem_sub[64]};
    assign q_fix   = neg_q ? -quo_nx : quo_nx;
    assign r_fix   = neg_r ? -rem_nx : rem_nx;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        resp_load    = 1'b0;
        resp_illegal = 1'b0;
        resp_value   = '0;
        mul_start    = 1'b0;
        div_start    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_div) begin
                        state_next = MUL_ISSUE;
                        mul_start  = 1'b1;
                    end else begin
`ifdef MDU_DIV_EN
                        if (div_zero) begin
                            state_next = RESP;
                            resp_load  = 1'b1;
                            resp_value = wext(in_word, op_rem ? ext_a : '1);
                        end else if (div_ovf) begin
                            state_next = RESP;
                            resp_load  = 1'b1;
                            resp_value = wext(in_word, op_rem ? '0 : ext_a);
                        end else begin
                            state_next = DIV_RUN;
                            div_start  = 1'b1;
                        end
`else
                        state_next   = RESP;
                        resp_load    = 1'b1;
                        resp_illegal = 1'b1;
`endif
                    end
                end
            end
            MUL_ISSUE: state_next = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_value = wext(word_q, mul_c);
                end
            end
`ifdef MDU_DIV_EN
            DIV_RUN: begin
                if (div_cnt == 7'd1) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    resp_value = wext(word_q, sel_rem ? r_fix : q_fix);
                end
            end
`endif
            RESP: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            resp_load  = 1'b0;
            mul_start  = 1'b0;
            div_start  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q      <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_data    <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (accept)
                word_q <= in_word;
            if (mul_start) begin
                mul_a <= ext_a;
                mul_b <= ext_b;
            end
            if (resp_load) begin
                out_data    <= resp_value;
                out_illegal <= resp_illegal;
            end else if (state_next != RESP) begin
                out_illegal <= 1'b0;
            end
        end
    end

`ifdef MDU_DIV_EN
    // W divides park the 32-bit dividend in the upper half so only 32 steps are needed
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_rem <= '0;
            div_quo <= '0;
            div_dsr <= '0;
            div_cnt <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
        end else if (div_start) begin
            div_rem <= '0;
            div_quo <= in_word ? {abs_a[31:0], 32'd0} : abs_a;
            div_dsr <= abs_b;
            div_cnt <= in_word ? 7'd32 : 7'd64;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            sel_rem <= op_rem;
        end else if (state == DIV_RUN) begin
            div_rem <= rem_nx;
            div_quo <= quo_nx;
            div_cnt <= div_cnt - 7'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
`timescale 1ns/1ps
// Directed self-checking bench for mdu_ctrl with a two-cycle multiplier model.
module tb_mdu_ctrl;

    localparam logic [2:0] MUL  = 3'd0;
    localparam logic [2:0] DIV  = 3'd1;
    localparam logic [2:0] DIVU = 3'd2;
    localparam logic [2:0] REM  = 3'd3;
    localparam logic [2:0] REMU = 3'd4;
    localparam logic [2:0] RSV7 = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_illegal;
    logic        mul_valid;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_c = '0;

    int nvec = 0;
    int nerr = 0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_illegal(out_illegal), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c)
    );

    always #5 clk = ~clk;

    // External multiplier: done and product one cycle after the start pulse
    always @(posedge clk) begin
        mul_done <= mul_valid;
        mul_c    <= mul_a * mul_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        in_op    = op;
        in_word  = w;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int exp_lat, input logic [63:0] exp_data);
        int lat;
        issue(op, w, a, b);
        wait_resp(lat);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " data"}, out_data, exp_data);
        chk1({tag, " illegal"}, out_illegal, 1'b0);
        step();
    endtask

    initial begin
        int lat;
        bit seen;

        step();
        step();
        chk1("reset in_ready", in_ready, 1'b0);
        chk1("reset out_valid", out_valid, 1'b0);
        chk1("reset mul_valid", mul_valid, 1'b0);
        chk1("reset out_illegal", out_illegal, 1'b0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset mul_a", mul_a, 64'd0);
        reset = 1'b1;
        step();
        chk1("idle in_ready", in_ready, 1'b1);

        // MUL -1 * 3 traced cycle by cycle, then a streamed reserved-op MUL
        issue(MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        chk1("mul issue pulse", mul_valid, 1'b1);
        chk("mul issue a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul issue b", mul_b, 64'd3);
        chk1("mul busy in_ready", in_ready, 1'b0);
        step();
        chk1("mul wait pulse", mul_valid, 1'b0);
        chk1("mul wait out_valid", out_valid, 1'b0);
        chk("mul wait a held", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk1("mul resp out_valid", out_valid, 1'b1);
        chk("mul resp data", out_data, 64'hFFFF_FFFF_FFFF_FFFD);
        in_op = RSV7; in_word = 1'b0; in_a = 64'd6; in_b = 64'd7; in_valid = 1'b1;
        step();
        chk1("stream idle in_ready", in_ready, 1'b1);
        chk1("stream no early accept", mul_valid, 1'b0);
        step();
        in_valid = 1'b0;
        chk1("stream accept pulse", mul_valid, 1'b1);
        wait_resp(lat);
        chk("rsv op latency", 64'(lat), 64'd3);
        chk("rsv op data", out_data, 64'd42);
        step();

        run("mulw", MUL, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 3, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(MUL, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'hFFFF_0000_0000_0005);
        chk("mulw sext a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mulw sext b", mul_b, 64'd5);
        wait_resp(lat);
        chk("mulw neg data", out_data, 64'hFFFF_FFFF_FFFF_FFFB);
        step();

        // Response held under backpressure
        out_ready = 1'b0;
        issue(MUL, 1'b0, 64'h1_0000_0000, 64'h10);
        wait_resp(lat);
        chk("hold latency", 64'(lat), 64'd3);
        chk("hold data", out_data, 64'h10_0000_0000);
        in_op = MUL; in_a = 64'd1; in_b = 64'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("hold out_valid", out_valid, 1'b1);
            chk("hold data stable", out_data, 64'h10_0000_0000);
            chk1("hold in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk1("release out_valid", out_valid, 1'b0);
        chk1("release in_ready", in_ready, 1'b1);
        issue(MUL, 1'b0, 64'd5, 64'd5);
        chk1("release next accept", mul_valid, 1'b1);
        wait_resp(lat);
        chk("release next data", out_data, 64'd25);
        step();

        // Flush in MUL_WAIT, then flush colliding with a request
        issue(MUL, 1'b0, 64'd11, 64'd13);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk1("flush out_valid", out_valid, 1'b0);
        chk1("flush mul_valid", mul_valid, 1'b0);
        chk1("flush in_ready", in_ready, 1'b1);
        in_op = MUL; in_a = 64'd2; in_b = 64'd2; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk1("flush blocks accept", mul_valid, 1'b0);
        chk1("flush blocks in_ready", in_ready, 1'b1);
        run("mul after flush", MUL, 1'b0, 64'd9, 64'd9, 3, 64'd81);

        // Reset in MUL_WAIT
        issue(MUL, 1'b0, 64'd3, 64'd4);
        step();
        reset = 1'b0;
        step();
        chk1("midreset out_valid", out_valid, 1'b0);
        chk1("midreset mul_valid", mul_valid, 1'b0);
        chk1("midreset in_ready", in_ready, 1'b0);
        chk("midreset out_data", out_data, 64'd0);
        chk("midreset mul_a", mul_a, 64'd0);
        chk("midreset mul_b", mul_b, 64'd0);
        reset = 1'b1;
        step();
        chk1("post reset in_ready", in_ready, 1'b1);
        run("mul after reset", MUL, 1'b0, 64'd3, 64'd4, 3, 64'd12);

`ifdef MDU_DIV_EN
        run("div", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run("div neg divisor", DIV, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem neg divisor", REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 64'd1);
        run("divu", DIVU, 1'b0, 64'd100, 64'd7, 65, 64'd14);
        run("remu", REMU, 1'b0, 64'd100, 64'd7, 65, 64'd2);
        run("divu big", DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 65, 64'h0FFF_FFFF_FFFF_FFFF);
        run("divu zero", DIVU, 1'b0, 64'd123, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu zero", REMU, 1'b0, 64'd123, 64'd0, 1, 64'd123);
        run("div ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
        run("divw ovf", DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000);
        run("remw ovf", REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'd0);
        run("divw", DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
        run("remw", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divuw", DIVU, 1'b1, 64'hAAAA_AAAA_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF);

        issue(DIV, 1'b0, 64'd100, 64'd7);
        for (int i = 0; i < 9; i++)
            step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid)
                seen = 1'b1;
            step();
        end
        chk1("div flush no result", seen, 1'b0);
        run("mul after div flush", MUL, 1'b0, 64'd6, 64'd7, 3, 64'd42);
`else
        issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        chk1("div off out_valid", out_valid, 1'b1);
        chk1("div off illegal", out_illegal, 1'b1);
        chk("div off data", out_data, 64'd0);
        step();
        chk1("div off drained", out_valid, 1'b0);
        issue(REMU, 1'b1, 64'd5, 64'd0);
        chk1("remuw off out_valid", out_valid, 1'b1);
        chk1("remuw off illegal", out_illegal, 1'b1);
        chk("remuw off data", out_data, 64'd0);
        step();
        run("mul after illegal", MUL, 1'b0, 64'd6, 64'd7, 3, 64'd42);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the execute-stage M-extension unit. Accepts one multiply or divide operation at a time from the execute stage and drives the external two-cycle DSP multiplier. It also runs an internal radix-2 restoring divider, applies RV64 word-op and divide corner-case rules, and holds the result until the pipeline takes it. It sits between the execute-stage operand muxes and the writeback result mux.

## Interface

Parameters:
- none; data width fixed at 64 (u64).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low. One clock; reset is sampled on the rising edge of `clk`.
- `in_valid` in 1: operation request.
- `in_ready` out 1: controller can accept; high only in IDLE and while `reset`=1.
- `in_op` in 3: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5–7 reserved, treated as MUL.
- `in_word` in 1: W variant (MULW/DIVW/…).
- `in_a`, `in_b` in 64: operands.
- `flush` in 1: abandon current operation.
- `out_valid` out 1: result available.
- `out_ready` in 1: pipeline consumes result.
- `out_data` out 64: result.
- `out_illegal` out 1: divide op requested with divider compiled out.
- `mul_valid` out 1: start pulse to multiplier.
- `mul_a`, `mul_b` out 64: multiplier operands.
- `mul_done` in 1: multiplier done.
- `mul_c` in 64: multiplier product, low 64 bits.

## Operation

States: IDLE, MUL_ISSUE, MUL_WAIT, DIV_RUN, RESP.

**Reset (`reset`=0 at an edge):**
- State becomes IDLE.
- `out_valid`, `out_data`, `out_illegal`, `mul_valid`, `mul_a`, `mul_b` become 0.
- Divider registers clear.
- `in_ready` is 0 while `reset`=0.

**Accept:** `in_valid & in_ready & !flush` at an edge latches op, word flag and operands.
- W variants: operands become the low 32 bits of `in_a`/`in_b`. They are sign-extended for MUL/DIV/REM and zero-extended for DIVU/REMU.

**Transition from IDLE on accept:**
- MUL → MUL_ISSUE.
- Divide with divisor 0 → RESP. Quotient = all ones; remainder = dividend.
- Signed divide overflow (dividend = most-negative, divisor = −1; 32-bit test for W) → RESP. Quotient = dividend; remainder = 0.
- Other divides → DIV_RUN, with the iteration counter loaded with 64, or 32 for W.

**Multiply states:**
- MUL_ISSUE: `mul_valid`=1 for exactly this cycle; `mul_a`/`mul_b` driven from the latched operands. `mul_done` is ignored this cycle. Next state is MUL_WAIT.
- MUL_WAIT: operands held stable. On `mul_done`=1, capture `mul_c` and go to RESP; otherwise remain in MUL_WAIT.

**DIV_RUN:**
- Each cycle shifts one quotient bit using absolute values of signed operands; counter decrements.
- At count 0 → RESP with sign fix-up applied:
  - Quotient negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
- REM/REMU select the remainder; DIV/DIVU select the quotient.

**RESP:**
- `out_valid`=1.
- `out_data`: W results are sign-extended from bit 31, for every op including DIVUW/REMUW.
- Leaves to IDLE on `out_ready`=1. `out_data` is stable while `out_valid`=1 and `out_ready`=0.

**Flush:**
- In any state → IDLE at the next edge. `out_valid` and `mul_valid` are 0 from the next cycle.
- An in-flight multiplier result is discarded.
- `flush` with `in_valid` in the same cycle does not accept.
- `flush` in RESP with `out_ready`=1: result is dropped (treated as a flush).

## Timing

Accept edge is N; all cycle numbers below are relative to it.
- MUL: MUL_ISSUE in N+1, MUL_WAIT in N+2 (`mul_done` expected 1), RESP in N+3.
- DIV/REM 64-bit: DIV_RUN in N+1..N+64, RESP in N+65.
- DIV/REM W: DIV_RUN in N+1..N+32, RESP in N+33.
- Divide-by-zero and overflow: RESP in N+1.
- Back-to-back throughput: with `out_ready` tied 1, next accept occurs in the cycle after RESP. A MUL stream therefore accepts every 4 cycles.
- `in_ready` is a pure decode of state; there is no combinational path from `in_valid` to `in_ready`.
- Reset or flush mid-DIV_RUN or mid-MUL_WAIT: the next operation restarts cleanly. The multiplier tolerates a new `mul_valid` two or more cycles after the previous one.

## Configuration

`MDU_DIV_EN`:
- **Defined:** divider, DIV_RUN state and divide corner cases compiled in; `out_illegal` tied 0.
- **Undefined:** no divider logic. Any accepted divide op goes to RESP in N+1 with `out_data`=0 and `out_illegal`=1. MUL behaviour is unchanged.

## Test plan

- MUL a=0xFFFF_FFFF_FFFF_FFFF (−1), b=3, `out_ready`=1 → `mul_valid` pulse in N+1; `out_valid` in N+3 with 0xFFFF_FFFF_FFFF_FFFD.
- MULW a=0x7FFF_FFFF, b=2 → `out_data`=0xFFFF_FFFF_FFFF_FFFE.
- DIV a=−7, b=2 → RESP in N+65, 0xFFFF_FFFF_FFFF_FFFD. REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU b=0 → RESP in N+1, all ones. DIVW with a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- RESP held with `out_ready`=0 for 5 cycles → `out_data` stable, `in_ready`=0. Then `out_ready`=1 → IDLE and new accept next cycle.
- `flush` in DIV_RUN cycle N+10 → `out_valid` never asserted. A MUL accepted immediately after produces the correct product. `reset`=0 mid-MUL_WAIT → all outputs 0 next cycle.
